// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RISC-V core.
// Detects load-use hazards, injects bubbles on hazards and flushes, and holds under memory stall.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_id,
    input  logic [XLEN-1:0]  pc_id,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rd_id,
    input  logic [XLEN-1:0]  rd1_id,
    input  logic [XLEN-1:0]  rd2_id,
    input  logic [XLEN-1:0]  imm_id,
    input  logic             register_write_id,
    input  logic             mem_read_id,
    input  logic             mem_write_id,
    input  logic             branch_id,
    input  logic             alu_src_id,
    input  logic [3:0]       alu_control_id,
    input  logic [1:0]       result_src_id,
    input  logic             pc_src_ex,
    input  logic             stall_mem,
    output logic             valid_ex,
    output logic [XLEN-1:0]  pc_ex,
    output logic [4:0]       rs1_ex,
    output logic [4:0]       rs2_ex,
    output logic [4:0]       rd_ex,
    output logic [XLEN-1:0]  rd1_ex,
    output logic [XLEN-1:0]  rd2_ex,
    output logic [XLEN-1:0]  imm_ex,
    output logic             register_write_ex,
    output logic             mem_read_ex,
    output logic             mem_write_ex,
    output logic             branch_ex,
    output logic             alu_src_ex,
    output logic [3:0]       alu_control_ex,
    output logic [1:0]       result_src_ex,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic [CNT_W-1:0] load_use_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic load_use;
    logic bubble;

    // A load targeting x0 never produces a value to wait for.
    assign load_use = valid_ex & mem_read_ex & (rd_ex != 5'd0) & valid_id &
                      ((rd_ex == rs1_id) | (rd_ex == rs2_id));
    assign bubble   = pc_src_ex | load_use;

    assign stall_f = stall_mem | (load_use & ~pc_src_ex);
    assign stall_d = stall_mem | (load_use & ~pc_src_ex);
    assign flush_d = pc_src_ex & ~stall_mem;

    always_ff @(posedge clk) begin
        if (reset || (!stall_mem && bubble)) begin
            // Bubble zeroes register indices too, so forwarding never matches it.
            valid_ex          <= 1'b0;
            pc_ex             <= '0;
            rs1_ex            <= '0;
            rs2_ex            <= '0;
            rd_ex             <= '0;
            rd1_ex            <= '0;
            rd2_ex            <= '0;
            imm_ex            <= '0;
            register_write_ex <= 1'b0;
            mem_read_ex       <= 1'b0;
            mem_write_ex      <= 1'b0;
            branch_ex         <= 1'b0;
            alu_src_ex        <= 1'b0;
            alu_control_ex    <= '0;
            result_src_ex     <= '0;
        end else if (!stall_mem) begin
            valid_ex          <= valid_id;
            pc_ex             <= pc_id;
            rs1_ex            <= rs1_id;
            rs2_ex            <= rs2_id;
            rd_ex             <= rd_id;
            rd1_ex            <= rd1_id;
            rd2_ex            <= rd2_id;
            imm_ex            <= imm_id;
            register_write_ex <= register_write_id;
            mem_read_ex       <= mem_read_id;
            mem_write_ex      <= mem_write_id;
            branch_ex         <= branch_id;
            alu_src_ex        <= alu_src_id;
            alu_control_ex    <= alu_control_id;
            result_src_ex     <= result_src_id;
        end
    end

    // Only one counter moves per edge: a flush shadows a coincident load-use.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_use_count <= '0;
            flush_count    <= '0;
        end else if (!stall_mem) begin
            if (pc_src_ex) begin
                if (flush_count != '1)
                    flush_count <= flush_count + CNT_ONE;
            end else if (load_use) begin
                if (load_use_count != '1)
                    load_use_count <= load_use_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, pass-through, load-use, x0 load,
// flush priority, memory-stall hold, counter saturation and reset mid-stall.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid_id;
    logic [XLEN-1:0]  pc_id, rd1_id, rd2_id, imm_id;
    logic [4:0]       rs1_id, rs2_id, rd_id;
    logic             register_write_id, mem_read_id, mem_write_id, branch_id, alu_src_id;
    logic [3:0]       alu_control_id;
    logic [1:0]       result_src_id;
    logic             pc_src_ex, stall_mem;
    logic             valid_ex;
    logic [XLEN-1:0]  pc_ex, rd1_ex, rd2_ex, imm_ex;
    logic [4:0]       rs1_ex, rs2_ex, rd_ex;
    logic             register_write_ex, mem_read_ex, mem_write_ex, branch_ex, alu_src_ex;
    logic [3:0]       alu_control_ex;
    logic [1:0]       result_src_ex;
    logic             stall_f, stall_d, flush_d;
    logic [CNT_W-1:0] load_use_count, flush_count;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid_id(valid_id), .pc_id(pc_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .rd1_id(rd1_id), .rd2_id(rd2_id), .imm_id(imm_id),
        .register_write_id(register_write_id), .mem_read_id(mem_read_id),
        .mem_write_id(mem_write_id), .branch_id(branch_id), .alu_src_id(alu_src_id),
        .alu_control_id(alu_control_id), .result_src_id(result_src_id),
        .pc_src_ex(pc_src_ex), .stall_mem(stall_mem),
        .valid_ex(valid_ex), .pc_ex(pc_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .rd1_ex(rd1_ex), .rd2_ex(rd2_ex), .imm_ex(imm_ex),
        .register_write_ex(register_write_ex), .mem_read_ex(mem_read_ex),
        .mem_write_ex(mem_write_ex), .branch_ex(branch_ex), .alu_src_ex(alu_src_ex),
        .alu_control_ex(alu_control_ex), .result_src_ex(result_src_ex),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .load_use_count(load_use_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd,
                             input logic mr, input logic mw, input logic rw);
        valid_id = v; pc_id = pc; rs1_id = rs1; rs2_id = rs2; rd_id = rd;
        mem_read_id = mr; mem_write_id = mw; register_write_id = rw;
        rd1_id = 32'h0; rd2_id = 32'h0; imm_id = 32'h0;
        branch_id = 1'b0; alu_src_id = 1'b0; alu_control_id = 4'h0;
        result_src_id = mr ? 2'd1 : 2'd0;
        #1;
    endtask

    initial begin
        int exp_lu;
        pc_src_ex = 1'b0; stall_mem = 1'b0;

        // Reset with every ID input nonzero
        reset = 1'b1;
        valid_id = 1; pc_id = 32'hDEAD_BEEF; rs1_id = 5; rs2_id = 6; rd_id = 7;
        rd1_id = 32'h1111; rd2_id = 32'h2222; imm_id = 32'h3333;
        register_write_id = 1; mem_read_id = 1; mem_write_id = 1; branch_id = 1;
        alu_src_id = 1; alu_control_id = 4'hF; result_src_id = 2'd3;
        step();
        chk("rst valid_ex", valid_ex, 0);
        chk("rst pc_ex", pc_ex, 0);
        chk("rst regs_ex", {rs1_ex, rs2_ex, rd_ex}, 0);
        chk("rst data_ex", rd1_ex | rd2_ex | imm_ex, 0);
        chk("rst ctrl_ex", {register_write_ex, mem_read_ex, mem_write_ex, branch_ex,
                            alu_src_ex, alu_control_ex, result_src_ex}, 0);
        chk("rst counters", {load_use_count, flush_count}, 0);
        chk("rst stall_f", stall_f, 0);
        chk("rst flush_d", flush_d, 0);
        reset = 1'b0;

        // Pass-through
        set_instr(1, 32'h100, 0, 7, 3, 0, 0, 1);
        step();
        chk("pass pc_ex", pc_ex, 32'h100);
        chk("pass rs2_ex", rs2_ex, 7);
        chk("pass rd_ex", rd_ex, 3);
        chk("pass rw_ex", register_write_ex, 1);
        chk("pass valid_ex", valid_ex, 1);

        // Load-use: lw x5 ; add x6,x5,x7
        set_instr(1, 32'h104, 1, 0, 5, 1, 0, 1);
        step();
        chk("lw mem_read_ex", mem_read_ex, 1);
        set_instr(1, 32'h108, 5, 7, 6, 0, 0, 1);
        chk("lu stall_f", stall_f, 1);
        chk("lu stall_d", stall_d, 1);
        chk("lu flush_d", flush_d, 0);
        step();
        chk("lu bubble valid_ex", valid_ex, 0);
        chk("lu bubble rd_ex", rd_ex, 0);
        chk("lu count", load_use_count, 1);
        chk("lu stall released", stall_f, 0);
        step();
        chk("lu add rs1_ex", rs1_ex, 5);
        chk("lu add pc_ex", pc_ex, 32'h108);
        chk("lu count hold", load_use_count, 1);

        // x0 load never stalls
        set_instr(1, 32'h10C, 1, 0, 0, 1, 0, 1);
        step();
        set_instr(1, 32'h110, 0, 0, 8, 0, 0, 1);
        chk("x0 stall_f", stall_f, 0);
        step();
        chk("x0 pc_ex", pc_ex, 32'h110);
        chk("x0 count", load_use_count, 1);

        // Store using loaded reg only as rs2 still stalls
        set_instr(1, 32'h114, 1, 0, 9, 1, 0, 1);
        step();
        set_instr(1, 32'h118, 2, 9, 0, 0, 1, 0);
        chk("st rs2 stall_f", stall_f, 1);
        step();
        chk("st rs2 bubble", valid_ex, 0);
        chk("st rs2 count", load_use_count, 2);
        step();
        chk("st advances", mem_write_ex, 1);
        exp_lu = 2;

        // Flush beats load-use
        set_instr(1, 32'h11C, 1, 0, 5, 1, 0, 1);
        step();
        set_instr(1, 32'h120, 5, 0, 6, 0, 0, 1);
        pc_src_ex = 1; #1;
        chk("fl flush_d", flush_d, 1);
        chk("fl stall_d", stall_d, 0);
        chk("fl stall_f", stall_f, 0);
        step();
        pc_src_ex = 0;
        chk("fl bubble", valid_ex, 0);
        chk("fl flush_count", flush_count, 1);
        chk("fl lu unchanged", load_use_count, exp_lu);

        // Hold under stall_mem, including coincident pc_src_ex
        set_instr(1, 32'h200, 1, 2, 4, 0, 0, 1);
        step();
        set_instr(1, 32'h300, 3, 3, 12, 0, 0, 1);
        stall_mem = 1; #1;
        for (int i = 0; i < 3; i++) begin
            pc_src_ex = (i == 1); #1;
            chk("hold stall_f", stall_f, 1);
            chk("hold flush_d", flush_d, 0);
            step();
            chk("hold pc_ex", pc_ex, 32'h200);
            chk("hold rd_ex", rd_ex, 4);
        end
        chk("hold flush_count", flush_count, 1);
        stall_mem = 0; pc_src_ex = 0; #1;
        step();
        chk("release pc_ex", pc_ex, 32'h300);

        // Saturation of load_use_count (2 bits)
        for (int i = 0; i < 5; i++) begin
            set_instr(1, 32'h400 + i * 8, 1, 0, 5, 1, 0, 1);
            step();
            set_instr(1, 32'h404 + i * 8, 5, 5, 6, 0, 0, 1);
            step();
            exp_lu = (exp_lu < 3) ? exp_lu + 1 : 3;
            chk("sat count", load_use_count, exp_lu);
            step();
        end
        chk("sat final", load_use_count, 3);

        // Reset asserted mid-stall
        set_instr(1, 32'h500, 1, 0, 5, 1, 0, 1);
        step();
        set_instr(1, 32'h504, 5, 0, 6, 0, 0, 1);
        chk("mid stall_f", stall_f, 1);
        reset = 1; #1;
        step();
        chk("mid valid_ex", valid_ex, 0);
        chk("mid counters", {load_use_count, flush_count}, 0);
        chk("mid stall_f", stall_f, 0);
        reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline boundary of the 5-stage RISC-V core, with load-use hazard detection. It captures decoded operands, register indices and control signals from Decode every cycle and presents them to Execute. Its `rs2_ex`, `rs1_ex` and `register_write_ex` outputs feed the EX-stage forwarding units. When a load in EX is followed by a dependent instruction in ID, it stalls Fetch/Decode and injects a bubble. It squashes on a taken branch and holds state under a global memory stall.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of the saturating event counters

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; all state cleared on the edge where reset=1
- valid_id  in  1  ID holds a real instruction
- pc_id  in  XLEN  PC of ID instruction
- rs1_id, rs2_id, rd_id  in  5 each  register indices
- rd1_id, rd2_id, imm_id  in  XLEN each  register-file read data, immediate
- register_write_id, mem_read_id, mem_write_id, branch_id, alu_src_id  in  1 each  control
- alu_control_id  in  4  ALU op
- result_src_id  in  2  writeback mux select
- pc_src_ex  in  1  taken branch/jump resolved in EX this cycle
- stall_mem  in  1  global back-pressure from the data memory
- valid_ex, pc_ex, rs1_ex, rs2_ex, rd_ex, rd1_ex, rd2_ex, imm_ex, register_write_ex, mem_read_ex, mem_write_ex, branch_ex, alu_src_ex, alu_control_ex, result_src_ex  out  same widths as the `_id` inputs  registered EX copies
- stall_f, stall_d  out  1  hold PC and IF/ID registers
- flush_d  out  1  clear IF/ID register
- load_use_count, flush_count  out  CNT_W each  saturating event counters

## Operation
- Combinational hazard detect: load_use = valid_ex & mem_read_ex & (rd_ex != 0) & valid_id & ((rd_ex == rs1_id) | (rd_ex == rs2_id)).
- Next-state priority, evaluated each rising edge:
  1. reset. All EX registers are cleared and both counters are cleared.
  2. stall_mem. All EX registers hold and both counters hold.
  3. pc_src_ex. A bubble is loaded and flush_count increments.
  4. load_use. A bubble is loaded and load_use_count increments.
  5. Otherwise, every `_ex` register loads its `_id` input.
- A bubble sets every EX register to 0, including rs1_ex, rs2_ex and rd_ex. Forwarding units therefore never match a bubble.
- Control outputs are combinational:
  - stall_f = stall_d = stall_mem | (load_use & ~pc_src_ex)
  - flush_d = pc_src_ex & ~stall_mem
- Counters saturate at all-ones and never wrap.
- A load with rd=x0 never causes a stall.
- A load followed by a store that uses the loaded register only as rs2 still stalls. No special case is made for this.

## Timing
- ID→EX latency: 1 cycle. A value on `_id` at edge N appears on `_ex` after edge N.
- A load-use stall lasts exactly 1 cycle. The following cycle has a bubble in EX, so load_use drops and the dependent instruction advances.
- Simultaneous pc_src_ex and load_use: the flush wins. In that cycle stall_f=0, stall_d=0, flush_d=1, a bubble enters EX, and only flush_count increments.
- Simultaneous stall_mem and pc_src_ex: the block holds and flush_d=0. pc_src_ex is still asserted next cycle, so the flush happens once stall_mem drops.
- Reset values: every output register is 0 and both counters are 0. After reset, stall_f, stall_d and flush_d follow their equations, which evaluate to 0 when inputs are idle.
- Reset asserted mid-stall: EX clears on that edge. The stall condition disappears because valid_ex=0.

## Test plan
- Reset: drive all `_id` inputs nonzero with reset=1 for 1 cycle. Expect all `_ex` outputs = 0, both counters = 0, stall_f=0, flush_d=0.
- Pass-through: pc_id=0x100, rs2_id=7, rd_id=3, register_write_id=1, valid_id=1. One cycle later expect pc_ex=0x100, rs2_ex=7, rd_ex=3, register_write_ex=1.
- Load-use: `lw x5` is in EX and `add x6,x5,x7` is in ID. Expect stall_f=stall_d=1 for exactly 1 cycle, then valid_ex=0 (bubble), then the add reaches EX with rs1_ex=5, and load_use_count=1.
- x0 load: `lw x0` is in EX and rs1_id=0 is in ID. Expect stall_f=0 and the instruction advances normally.
- Flush vs load-use: pc_src_ex=1 in the same cycle as a load-use match. Expect flush_d=1, stall_d=0, a bubble, flush_count=1, and load_use_count unchanged.
- Hold and saturation: assert stall_mem for 3 cycles. Expect `_ex` values unchanged and stall_f=1. With CNT_W=2, trigger 5 load-use events and expect load_use_count=3.
